// File: rtl/uart_pkg.sv
// Shared types and constants for the UART message sender: baud default,
// transmitter and message state encodings, and the fixed message ROM.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int MSG_LEN          = 14;
    localparam int IDX_W            = $clog2(MSG_LEN);

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

    typedef enum logic {
        M_IDLE,
        M_SEND
    } msg_state_t;

    // "Hello World!\r\n", byte 0 in the least significant position
    localparam logic [MSG_LEN*8-1:0] MSG_ROM = {
        8'h0A, 8'h0D, 8'h21, 8'h64, 8'h6C, 8'h72, 8'h6F,
        8'h57, 8'h20, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48
    };

    function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx);
        return MSG_ROM[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_ctrl_if.sv
// Byte handshake between the message sequencer (master) and the serial
// transmitter (slave).
interface uart_ctrl_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter, LSB first, registered line output.
// tx_done is raised during the last clock of the stop bit so the sequencer
// can start the next byte with at most one idle clock between frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    uart_ctrl_if.slave  bus,
    output logic        tx_line
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        data_q, data_d;
    logic              line_q, line_d;
    logic              done_q, done_d;
    logic              baud_end;
    logic [2:0]        bit_next;

    // Next-state logic: each state holds the line for one full bit period
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        data_d   = data_q;
        line_d   = line_q;
        done_d   = 1'b0;
        baud_end = (baud_q == BAUD_LAST);
        bit_next = bit_q + 3'd1;
        case (state_q)
            T_IDLE: begin
                line_d = 1'b1;
                if (bus.tx_start) begin
                    data_d  = bus.tx_data;
                    baud_d  = '0;
                    line_d  = 1'b0;
                    state_d = T_START;
                end
            end
            T_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    line_d  = data_q[0];
                    state_d = T_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            T_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        line_d  = 1'b1;
                        state_d = T_STOP;
                    end else begin
                        bit_d  = bit_next;
                        line_d = data_q[bit_next];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            T_STOP: begin
                if (baud_q == BAUD_PRE) begin
                    done_d = 1'b1;
                end
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = T_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                line_d  = 1'b1;
                state_d = T_IDLE;
            end
        endcase
    end

    // State registers; reset drives the line idle high on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            data_q  <= 8'd0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx_busy = (state_q != T_IDLE);
    assign bus.tx_done = done_q;
    assign tx_line     = line_q;

endmodule

// File: rtl/uart_ctrl.sv
// Board-level message sender: a rising edge on SW1 transmits the ROM message
// once over UART_RXD_OUT. SW0 is a synchronous reset.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic CLK100MHZ,
    input  logic SW0,
    input  logic SW1,
    output logic UART_RXD_OUT
);

    uart_ctrl_if tx_bus ();

    logic             sw_s1_q, sw_s1_d;
    logic             sw_s2_q, sw_s2_d;
    logic             sw_d_q, sw_d_d;
    logic [1:0]       fill_q, fill_d;
    logic             armed_q, armed_d;
    logic             start;
    msg_state_t       msg_state_q, msg_state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_next;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;

    // Synchroniser, edge detect and message sequencer next-state logic.
    // The synchroniser flops clear on reset, so a switch already held high
    // would look like a fresh edge; the edge detector is only armed once a
    // genuine low sample has passed through the synchroniser.
    always_comb begin
        sw_s1_d     = SW1;
        sw_s2_d     = sw_s1_q;
        sw_d_d      = sw_s2_q;
        fill_d      = {fill_q[0], 1'b1};
        armed_d     = armed_q | (fill_q[1] & ~sw_s2_q);
        start       = sw_s2_q & ~sw_d_q & armed_q;
        msg_state_d = msg_state_q;
        idx_d       = idx_q;
        idx_next    = idx_q + 1'b1;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        case (msg_state_q)
            M_IDLE: begin
                if (start && !tx_bus.tx_busy) begin
                    idx_d       = '0;
                    tx_start_d  = 1'b1;
                    tx_data_d   = msg_byte(IDX_W'(0));
                    msg_state_d = M_SEND;
                end
            end
            M_SEND: begin
                if (tx_bus.tx_done) begin
                    if (idx_q == IDX_W'(MSG_LEN - 1)) begin
                        msg_state_d = M_IDLE;
                    end else begin
                        idx_d      = idx_next;
                        tx_start_d = 1'b1;
                        tx_data_d  = msg_byte(idx_next);
                    end
                end
            end
            default: msg_state_d = M_IDLE;
        endcase
    end

    // Registers for the synchroniser, arming logic and message sequencer
    always_ff @(posedge CLK100MHZ) begin
        if (SW0) begin
            sw_s1_q     <= 1'b0;
            sw_s2_q     <= 1'b0;
            sw_d_q      <= 1'b0;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
            msg_state_q <= M_IDLE;
            idx_q       <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'd0;
        end else begin
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
            sw_d_q      <= sw_d_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            msg_state_q <= msg_state_d;
            idx_q       <= idx_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign tx_bus.tx_start = tx_start_q;
    assign tx_bus.tx_data  = tx_data_q;

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (CLK100MHZ),
        .rst    (SW0),
        .bus    (tx_bus),
        .tx_line(UART_RXD_OUT)
    );

endmodule

// File: tb/tb_uart_ctrl.sv
// Testbench for uart_ctrl: a line decoder checks every frame against a
// scoreboard of expected bytes filled whenever a message request is driven.
module tb_uart_ctrl;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int NMSG  = 14;

    logic clk = 1'b0;
    logic sw0 = 1'b1;
    logic sw1 = 1'b0;
    logic line;

    logic [7:0] exp_msg [NMSG] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                                   8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] sb_q [$];

    bit         active = 1'b0;
    int         pos = 0;
    bit         frame_ok = 1'b1;
    logic [7:0] shreg = 8'd0;
    logic       bitv = 1'b0;
    int         frames_done = 0;
    int         idle_run = 0;
    int         max_gap = 0;
    bit         first_of_msg = 1'b0;
    int         msg_start_cyc = 0;
    bit         low_seen = 1'b0;
    logic [7:0] exp_byte;

    uart_ctrl #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK100MHZ   (clk),
        .SW0         (sw0),
        .SW1         (sw1),
        .UART_RXD_OUT(line)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Free-running cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: walks each frame clock by clock, checks bit widths and
    // levels, then compares the decoded byte with the scoreboard head
    always @(negedge clk) begin
        if (line === 1'b0) low_seen = 1'b1;
        if (sw0) begin
            active   = 1'b0;
            idle_run = 0;
        end else if (!active) begin
            if (line === 1'b0) begin
                active   = 1'b1;
                pos      = 1;
                frame_ok = 1'b1;
                shreg    = 8'd0;
                if (first_of_msg) begin
                    msg_start_cyc = cyc;
                    first_of_msg  = 1'b0;
                end else if (idle_run > max_gap) begin
                    max_gap = idle_run;
                end
            end else begin
                idle_run++;
            end
        end else begin
            if (pos / CPB == 0) begin
                if (line !== 1'b0) frame_ok = 1'b0;
            end else if (pos / CPB <= 8) begin
                if (pos % CPB == 0) begin
                    bitv = line;
                    shreg[3'(pos / CPB - 1)] = line;
                end else if (line !== bitv) begin
                    frame_ok = 1'b0;
                end
            end else begin
                if (line !== 1'b1) frame_ok = 1'b0;
            end
            pos++;
            if (pos == FRAME) begin
                active   = 1'b0;
                idle_run = 0;
                frames_done++;
                n_checks++;
                assert (frame_ok === 1'b1) n_pass++;
                else begin
                    n_fail++;
                    $error("[TB] FAIL frame_format: observed ok=%0b expected 1 (frame %0d)", frame_ok, frames_done);
                end
                n_checks++;
                assert (sb_q.size() != 0) n_pass++;
                else begin
                    n_fail++;
                    $error("[TB] FAIL unexpected_frame: observed byte %02h with empty scoreboard expected none", shreg);
                end
                if (sb_q.size() != 0) begin
                    exp_byte = sb_q.pop_front();
                    n_checks++;
                    assert (shreg === exp_byte) n_pass++;
                    else begin
                        n_fail++;
                        $error("[TB] FAIL byte: observed %02h expected %02h", shreg, exp_byte);
                    end
                end
            end
        end
    end

    // Advance n clocks, leaving time just after a rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive switches then let the design run for n clocks
    task automatic apply_stimulus(input logic rst_v, input logic sw_v, input int n);
        sw0 = rst_v;
        sw1 = sw_v;
        step(n);
    endtask

    // Queue the expected message ahead of requesting it
    task automatic push_msg();
        foreach (exp_msg[i]) sb_q.push_back(exp_msg[i]);
        first_of_msg = 1'b1;
        max_gap      = 0;
    endtask

    // Wait until the decoder has counted target frames or the budget expires
    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (frames_done < target && k < budget) begin
            step(1);
            k++;
        end
        n_checks++;
        assert (frames_done >= target) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL wait_frames: observed %0d frames expected %0d", frames_done, target);
        end
    endtask

    initial begin
        int base;
        int t0;
        int lat;

        // Test 1: reset held with SW1 low keeps the line idle high
        apply_stimulus(1'b1, 1'b0, 2);
        low_seen = 1'b0;
        step(100);
        n_checks++;
        assert (low_seen === 1'b0) n_pass++;
        else begin n_fail++; $error("[TB] FAIL reset_no_low: observed %0b expected 0", low_seen); end
        n_checks++;
        assert (line === 1'b1) n_pass++;
        else begin n_fail++; $error("[TB] FAIL reset_line: observed %0b expected 1", line); end

        // Test 2: SW1 rising and held sends exactly one message
        apply_stimulus(1'b0, 1'b0, 10);
        base = frames_done;
        push_msg();
        t0 = cyc;
        apply_stimulus(1'b0, 1'b1, 1000);
        lat = msg_start_cyc - t0;
        n_checks++;
        assert (frames_done - base === NMSG) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t2_frames: observed %0d expected %0d", frames_done - base, NMSG); end
        n_checks++;
        assert (sb_q.size() === 0) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t2_pending: observed %0d expected 0", sb_q.size()); end
        n_checks++;
        assert (lat >= 1 && lat <= 5) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t2_latency: observed %0d expected 1..5", lat); end
        n_checks++;
        assert (max_gap <= 1) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t2_gap: observed %0d expected <=1", max_gap); end
        n_checks++;
        assert (line === 1'b1) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t2_line_after: observed %0b expected 1", line); end

        // Test 3: a new edge during the message is ignored
        apply_stimulus(1'b0, 1'b0, 10);
        base = frames_done;
        push_msg();
        apply_stimulus(1'b0, 1'b1, 1);
        wait_frames(base + 3, 600);
        apply_stimulus(1'b0, 1'b1, 10);
        apply_stimulus(1'b0, 1'b0, 10);
        apply_stimulus(1'b0, 1'b1, 1300);
        n_checks++;
        assert (frames_done - base === NMSG) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t3_frames: observed %0d expected %0d", frames_done - base, NMSG); end
        n_checks++;
        assert (sb_q.size() === 0) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t3_pending: observed %0d expected 0", sb_q.size()); end

        // Test 4: a fresh edge after completion sends a second message
        apply_stimulus(1'b0, 1'b0, 10);
        base = frames_done;
        push_msg();
        apply_stimulus(1'b0, 1'b1, 700);
        n_checks++;
        assert (frames_done - base === NMSG) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t4_frames: observed %0d expected %0d", frames_done - base, NMSG); end
        n_checks++;
        assert (sb_q.size() === 0) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t4_pending: observed %0d expected 0", sb_q.size()); end
        n_checks++;
        assert (max_gap <= 1) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t4_gap: observed %0d expected <=1", max_gap); end

        // Test 5: reset mid-frame aborts; held SW1 does not retrigger
        apply_stimulus(1'b0, 1'b0, 10);
        base = frames_done;
        push_msg();
        apply_stimulus(1'b0, 1'b1, 1);
        wait_frames(base + 5, 600);
        step(3 * CPB + 1);
        apply_stimulus(1'b1, 1'b1, 1);
        n_checks++;
        assert (line === 1'b1) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t5_abort_line: observed %0b expected 1", line); end
        n_checks++;
        assert (sb_q.size() === NMSG - 5) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t5_partial: observed %0d expected %0d", sb_q.size(), NMSG - 5); end
        sb_q.delete();
        low_seen = 1'b0;
        apply_stimulus(1'b1, 1'b1, 4);
        apply_stimulus(1'b0, 1'b1, 300);
        n_checks++;
        assert (low_seen === 1'b0) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t5_no_resend: observed low=%0b expected 0", low_seen); end
        n_checks++;
        assert (frames_done - base === 5) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t5_frames: observed %0d expected 5", frames_done - base); end
        apply_stimulus(1'b0, 1'b0, 10);
        base = frames_done;
        push_msg();
        apply_stimulus(1'b0, 1'b1, 700);
        n_checks++;
        assert (frames_done - base === NMSG) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t5_rearm_frames: observed %0d expected %0d", frames_done - base, NMSG); end
        n_checks++;
        assert (sb_q.size() === 0) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t5_pending: observed %0d expected 0", sb_q.size()); end

        // Test 6: a two-clock pulse on SW1 still sends the whole message
        apply_stimulus(1'b0, 1'b0, 10);
        base = frames_done;
        push_msg();
        apply_stimulus(1'b0, 1'b1, 2);
        apply_stimulus(1'b0, 1'b0, 700);
        n_checks++;
        assert (frames_done - base === NMSG) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t6_frames: observed %0d expected %0d", frames_done - base, NMSG); end
        n_checks++;
        assert (sb_q.size() === 0) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t6_pending: observed %0d expected 0", sb_q.size()); end
        n_checks++;
        assert (line === 1'b1) n_pass++;
        else begin n_fail++; $error("[TB] FAIL t6_line_after: observed %0b expected 1", line); end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
